// File: rtl/contador_tempo_musica_pkg.sv
// Shared timing and skip constants for the playback address and time-display stages,
// plus the mm:ss digit record and the helpers that build it.
package contador_tempo_musica_pkg;

  localparam int CLK_HZ  = 3000;
  localparam int MAX_SEG = 5999;
  localparam int PRE_W   = $clog2(CLK_HZ);

  localparam logic signed [8:0] SKIP_10 = 9'sd10;
  localparam logic signed [8:0] SKIP_30 = 9'sd30;

  typedef struct packed {
    logic [3:0] min_dez;
    logic [3:0] min_unid;
    logic [3:0] seg_dez;
    logic [3:0] seg_unid;
  } bcd_t;

  function automatic logic ajuste_legal(input logic signed [8:0] a);
    return (a == SKIP_10) || (a == -SKIP_10) || (a == SKIP_30) || (a == -SKIP_30);
  endfunction

  // Double dabble: 7-bit binary to two BCD digits (valid for inputs up to 99).
  function automatic logic [7:0] bin7_para_bcd(input logic [6:0] bin);
    logic [14:0] sr;
    sr = {8'd0, bin};
    for (int i = 0; i < 7; i++) begin
      if (sr[10:7] >= 4'd5)  sr[10:7]  = sr[10:7] + 4'd3;
      if (sr[14:11] >= 4'd5) sr[14:11] = sr[14:11] + 4'd3;
      sr = sr << 1;
    end
    return sr[14:7];
  endfunction

endpackage

// File: rtl/contador_tempo_musica_segundos_para_bcd.sv
// Combinational seconds -> mm:ss BCD split; no latency, no flow control.
module segundos_para_bcd
  import contador_tempo_musica_pkg::*;
(
  input  logic [12:0] segundos,
  output bcd_t        digitos
);

  logic [6:0] minutos;
  logic [5:0] resto;
  logic [7:0] min_bcd;
  logic [7:0] seg_bcd;

  assign minutos = 7'(segundos / 13'd60);
  assign resto   = 6'(segundos % 13'd60);
  assign min_bcd = bin7_para_bcd(minutos);
  assign seg_bcd = bin7_para_bcd({1'b0, resto});

  always_comb begin
    digitos          = '0;
    digitos.min_dez  = min_bcd[7:4];
    digitos.min_unid = min_bcd[3:0];
    digitos.seg_dez  = seg_bcd[7:4];
    digitos.seg_unid = seg_bcd[3:0];
  end

endmodule

// File: rtl/contador_tempo_musica.sv
// Elapsed-track-time counter: 1 s per CLK_HZ enabled cycles, saturating skips, mm:ss digits
// registered one cycle behind the seconds register; no handshake, skip strobes are fire-and-forget.
module contador_tempo_musica
  import contador_tempo_musica_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              count,
  input  logic              prox_musica,
  input  logic              ajuste_valido,
  input  logic signed [8:0] ajuste,
  output logic [12:0]       segundos_total,
  output logic [3:0]        seg_unid,
  output logic [3:0]        seg_dez,
  output logic [3:0]        min_unid,
  output logic [3:0]        min_dez
);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [12:0]       sec_q, sec_d;
  bcd_t              bcd_q, bcd_d;
  logic              tick;
  logic signed [14:0] delta;
  logic signed [14:0] soma;

  always_comb begin
    pre_d = pre_q;
    sec_d = sec_q;
    tick  = 1'b0;
    delta = '0;
    soma  = '0;
    if (prox_musica) begin
      pre_d = '0;
      sec_d = '0;
    end else if (count) begin
      tick  = (pre_q == PRE_W'(CLK_HZ - 1));
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      if (ajuste_valido && ajuste_legal(ajuste))
        delta = {{6{ajuste[8]}}, ajuste};
      // Skip and tick land together; clamp to 0..MAX_SEG so nothing wraps.
      soma = $signed({2'b00, sec_q}) + delta + $signed({14'd0, tick});
      if (soma[14])
        sec_d = '0;
      else if (soma > $signed(15'(MAX_SEG)))
        sec_d = 13'(MAX_SEG);
      else
        sec_d = soma[12:0];
    end
  end

  segundos_para_bcd u_bcd (
    .segundos (sec_q),
    .digitos  (bcd_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      sec_q <= '0;
      bcd_q <= '0;
    end else begin
      pre_q <= pre_d;
      sec_q <= sec_d;
      bcd_q <= bcd_d;
    end
  end

  assign segundos_total = sec_q;
  assign min_dez        = bcd_q.min_dez;
  assign min_unid       = bcd_q.min_unid;
  assign seg_dez        = bcd_q.seg_dez;
  assign seg_unid       = bcd_q.seg_unid;

endmodule

// File: tb/tb_contador_tempo_musica.sv
// Directed and randomized checks of the elapsed-time counter against a cycle-level arithmetic model.
module tb_contador_tempo_musica;

  localparam int HZ  = 3000;
  localparam int MAX = 5999;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              count = 1'b0;
  logic              prox_musica = 1'b0;
  logic              ajuste_valido = 1'b0;
  logic signed [8:0] ajuste = '0;
  logic [12:0]       segundos_total;
  logic [3:0]        seg_unid, seg_dez, min_unid, min_dez;

  contador_tempo_musica dut (
    .clk            (clk),
    .reset          (reset),
    .count          (count),
    .prox_musica    (prox_musica),
    .ajuste_valido  (ajuste_valido),
    .ajuste         (ajuste),
    .segundos_total (segundos_total),
    .seg_unid       (seg_unid),
    .seg_dez        (seg_dez),
    .min_unid       (min_unid),
    .min_dez        (min_dez)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: phase within the current second, elapsed seconds, and the value the display shows.
  int phase_m = 0;
  int sec_m   = 0;
  int disp_m  = 0;
  bit sec_ok  = 0;
  bit disp_ok = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] mmss(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] digits();
    return {min_dez, min_unid, seg_dez, seg_unid};
  endfunction

  task automatic step(input bit r, input bit c, input bit p, input bit v, input int aj);
    int s;
    int d;
    reset = r; count = c; prox_musica = p; ajuste_valido = v; ajuste = 9'(aj);
    @(posedge clk);
    disp_ok = r || sec_ok;
    disp_m  = r ? 0 : sec_m;
    if (r || p) begin
      phase_m = 0;
      sec_m   = 0;
      sec_ok  = 1;
    end else if (c) begin
      d = (v && (aj inside {10, -10, 30, -30})) ? aj : 0;
      s = sec_m + d;
      phase_m = phase_m + 1;
      if (phase_m == HZ) begin
        phase_m = 0;
        s = s + 1;
      end
      if (s < 0)   s = 0;
      if (s > MAX) s = MAX;
      sec_m = s;
    end
    #1;
    if (sec_ok)  check("sec", 32'(segundos_total), 32'(sec_m));
    if (disp_ok) check("bcd", 32'(digits()), 32'(mmss(disp_m)));
  endtask

  task automatic run(input int n, input bit c);
    repeat (n) step(0, c, 0, 0, 0);
  endtask

  initial begin
    int sel;
    int k;
    int aj_tab[10] = '{10, -10, 30, -30, 30, 1, 7, -1, 0, 100};

    step(1, 0, 0, 0, 0);
    check("rst_sec", 32'(segundos_total), 0);
    check("rst_bcd", 32'(digits()), 0);

    run(2999, 1);
    check("before_tick", 32'(segundos_total), 0);
    run(1, 1);
    check("tick_3000", 32'(segundos_total), 1);
    step(0, 0, 0, 0, 0);
    check("bcd_0001", 32'(digits()), 32'h0001);
    run(5000, 0);
    check("hold_count0", 32'(segundos_total), 1);

    repeat (200) step(0, 1, 0, 1, 30);
    check("sat_up", 32'(segundos_total), MAX);
    repeat (198) step(0, 1, 0, 1, -30);
    check("sec_59", 32'(segundos_total), 59);
    k = 0;
    while (segundos_total == 13'd59 && k < 3100) begin
      run(1, 1);
      k++;
    end
    check("sec_60", 32'(segundos_total), 60);
    step(0, 0, 0, 0, 0);
    check("bcd_0100", 32'(digits()), 32'h0100);

    step(0, 0, 1, 0, 0);
    check("prox_clear", 32'(segundos_total), 0);
    run(15000, 1);
    check("sec_5", 32'(segundos_total), 5);
    step(0, 1, 0, 1, 10);
    step(0, 1, 0, 1, 10);
    check("sec_25", 32'(segundos_total), 25);
    step(0, 1, 0, 1, -10);
    check("skip_m10", 32'(segundos_total), 15);
    step(0, 1, 0, 1, 10);
    step(0, 1, 0, 1, -30);
    check("clamp_0", 32'(segundos_total), 0);
    repeat (199) step(0, 1, 0, 1, 30);
    step(0, 1, 0, 1, 10);
    step(0, 1, 0, 1, 10);
    check("sec_5990", 32'(segundos_total), 5990);
    step(0, 1, 0, 1, 30);
    check("clamp_max", 32'(segundos_total), MAX);
    run(3100, 1);
    check("max_hold", 32'(segundos_total), MAX);
    step(0, 0, 0, 0, 0);
    check("bcd_9959", 32'(digits()), 32'h9959);

    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 10);
    step(0, 1, 0, 1, 10);
    run(2997, 1);
    check("sec_20", 32'(segundos_total), 20);
    step(0, 1, 0, 1, -10);
    check("tick_and_skip", 32'(segundos_total), 11);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 7);
    check("illegal_skip", 32'(segundos_total), 11);

    step(0, 1, 0, 1, 30);
    run(2997, 1);
    check("sec_42", 32'(segundos_total), 42);
    run(1500, 1);
    step(0, 1, 1, 0, 0);
    check("mid_prox", 32'(segundos_total), 0);
    run(2999, 1);
    check("no_early_tick", 32'(segundos_total), 0);
    run(1, 1);
    check("tick_after_prox", 32'(segundos_total), 1);

    step(1, 1, 0, 1, 30);
    check("rst_strobe", 32'(segundos_total), 0);
    step(0, 0, 0, 0, 0);
    check("rst_bcd_next", 32'(digits()), 0);

    repeat (6000) begin
      sel = int'($urandom_range(0, 9));
      step($urandom_range(0, 699) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0, aj_tab[sel]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
